// File: rtl/odd_parity_scheduler.sv
// Round-robin scheduler sharing one bit-serial odd-parity engine among R requesters.
// A granted word is shifted through a 1-bit XOR accumulator, then held on a valid/ready output port.
module odd_parity_scheduler #(
    parameter int N = 4,
    parameter int R = 4,
    localparam int ID_W = (R > 2) ? $clog2(R) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [R-1:0]      req_valid,
    input  logic [R*N-1:0]    req_data,
    output logic [R-1:0]      req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic              out_parity,
    output logic [ID_W-1:0]   out_id
);

    localparam int CNT_W = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [ID_W-1:0]   last;
    logic [ID_W-1:0]   id_reg;
    logic [N-1:0]      data_reg;
    logic              acc;
    logic [CNT_W-1:0]  cnt;

    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [N-1:0]      grant_data;
    logic              cur_bit;
    logic              last_bit;

    // Two-pass priority search: indices above the pointer first, then wrap to the rest.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = 0; i < R; i++) begin
            if (!grant_found && req_valid[i] && (ID_W'(i) > last)) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(i);
            end
        end
        for (int i = 0; i < R; i++) begin
            if (!grant_found && req_valid[i] && (ID_W'(i) <= last)) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < R; i++) begin
            if (ID_W'(i) == grant_id) begin
                grant_data = req_data[i*N +: N];
            end
        end
    end

    assign cur_bit  = |(data_reg & (N'(1) << cnt));
    assign last_bit = (cnt == CNT_W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state always uses non-blocking assignments to avoid read/write races.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_found) next_state = SHIFT;
            SHIFT:   if (last_bit)    next_state = DONE;
            DONE:    if (out_ready)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
        out_valid = (state == DONE);
    end

    // Output registers load once per word so they stay stable through any DONE stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last       <= ID_W'(R - 1);
            id_reg     <= '0;
            data_reg   <= '0;
            acc        <= 1'b0;
            cnt        <= '0;
            out_data   <= '0;
            out_parity <= 1'b0;
            out_id     <= '0;
        end else if (state == IDLE && grant_found) begin
            data_reg <= grant_data;
            id_reg   <= grant_id;
            last     <= grant_id;
            acc      <= 1'b0;
            cnt      <= '0;
        end else if (state == SHIFT) begin
            acc <= acc ^ cur_bit;
            cnt <= cnt + CNT_W'(1);
            if (last_bit) begin
                out_data   <= data_reg;
                out_parity <= ~(acc ^ cur_bit);
                out_id     <= id_reg;
            end
        end
    end

endmodule

// File: tb/tb_odd_parity_scheduler.sv
// Directed scoreboard bench for odd_parity_scheduler (N=4/R=4 main instance, N=8 instance for the wide rerun).
module tb_odd_parity_scheduler;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int N8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [R-1:0]     req_valid;
    logic [R*N-1:0]   req_data;
    logic [R-1:0]     req_ready;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic             out_parity;
    logic [1:0]       out_id;

    logic [R-1:0]     req_valid8;
    logic [R*N8-1:0]  req_data8;
    logic [R-1:0]     req_ready8;
    logic             out_valid8;
    logic             out_ready8;
    logic [N8-1:0]    out_data8;
    logic             out_parity8;
    logic [1:0]       out_id8;

    odd_parity_scheduler #(.N(N), .R(R)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_parity(out_parity), .out_id(out_id)
    );

    odd_parity_scheduler #(.N(N8), .R(R)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid8), .req_data(req_data8), .req_ready(req_ready8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_data(out_data8), .out_parity(out_parity8), .out_id(out_id8)
    );

    typedef struct {
        logic [N-1:0] data;
        logic         parity;
        logic [1:0]   id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] d, input logic p, input logic [1:0] id);
        exp_t e;
        e.data   = d;
        e.parity = p;
        e.id     = id;
        sb.push_back(e);
    endtask

    task automatic wait_grant(input string tag, output int gid);
        gid = -1;
        #1;
        for (int k = 0; k < 40; k++) begin
            if (|req_ready) break;
            step();
        end
        for (int i = 0; i < R; i++) begin
            if (req_ready[i]) gid = i;
        end
        checks++;
        assert (gid >= 0) else begin
            failures++;
            $error("FAIL %s_timeout observed=none expected=grant", tag);
        end
    endtask

    task automatic send(input string tag, input int id, input logic [N-1:0] d);
        int g;
        req_data[id*N +: N] = d;
        req_valid[id]       = 1'b1;
        wait_grant(tag, g);
        check({tag, "_gid"}, g, id);
        step();
        req_valid[id] = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 60; k++) begin
            if (sb.size() == 0) break;
            step();
        end
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL %s_drain observed=%0d expected=0", tag, sb.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_parity", out_parity, 0);
        step();
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: a result is consumed on the edge following a valid&ready sample.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_out observed=%0h expected=none", out_data);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("out_data", out_data, mon_e.data);
                check("out_parity", out_parity, mon_e.parity);
                check("out_id", out_id, mon_e.id);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int prev;
        int order4[4];

        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        out_ready  = 1'b1;
        req_valid8 = '0;
        req_data8  = '0;
        out_ready8 = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_parity", out_parity, 0);
        check("rst_out_id", out_id, 0);
        check("rst_req_ready", req_ready, 0);
        step();
        rst_n = 1'b1;

        // Single word 0000 on requester 0: one-cycle ready pulse, result N cycles later
        req_data[3:0] = 4'b0000;
        req_valid     = 4'b0001;
        push(4'b0000, 1'b1, 2'd0);
        #1;
        check("t1_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        #1;
        check("t1_ready_drop", req_ready, 0);
        repeat (3) step();
        check("t1_latency_early", out_valid, 0);
        step();
        check("t1_latency", out_valid, 1);
        drain("t1");

        // Requester 3 alone: 0111 then 1111
        push(4'b0111, 1'b0, 2'd3);
        send("t2a", 3, 4'b0111);
        drain("t2a");
        push(4'b1111, 1'b1, 2'd3);
        send("t2b", 3, 4'b1111);
        drain("t2b");

        // All four requesters valid from reset: order 0..3, spacing N+2
        do_reset();
        for (int i = 0; i < R; i++) req_data[i*N +: N] = N'(i + 1);
        req_valid = 4'b1111;
        push(4'b0001, 1'b0, 2'd0);
        push(4'b0010, 1'b0, 2'd1);
        push(4'b0011, 1'b1, 2'd2);
        push(4'b0100, 1'b0, 2'd3);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant("t3", g);
            check("t3_order", g, k);
            if (k > 0) check("t3_spacing", cyc - prev, 6);
            prev = cyc;
            step();
            if (g >= 0) req_valid[g] = 1'b0;
        end
        drain("t3");

        // Requesters 0 and 2 held continuously: strict alternation
        req_data[0*N +: N] = 4'b1000;
        req_data[2*N +: N] = 4'b1001;
        req_valid = 4'b0101;
        order4 = '{0, 2, 0, 2};
        push(4'b1000, 1'b0, 2'd0);
        push(4'b1001, 1'b1, 2'd2);
        push(4'b1000, 1'b0, 2'd0);
        push(4'b1001, 1'b1, 2'd2);
        for (int k = 0; k < 4; k++) begin
            wait_grant("t4", g);
            check("t4_order", g, order4[k]);
            step();
        end
        req_valid = '0;
        drain("t4");

        // Backpressure in DONE: outputs hold, no grants while stalled
        out_ready = 1'b0;
        push(4'b1010, 1'b1, 2'd1);
        send("t5", 1, 4'b1010);
        req_data[3*N +: N] = 4'b0000;
        req_valid[3]       = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            step();
        end
        for (int k = 0; k < 5; k++) begin
            check("t5_hold_valid", out_valid, 1);
            check("t5_hold_data", out_data, 4'b1010);
            check("t5_hold_parity", out_parity, 1);
            check("t5_hold_id", out_id, 1);
            check("t5_hold_ready", req_ready, 0);
            step();
        end
        req_valid[3] = 1'b0;
        out_ready    = 1'b1;
        step();
        check("t5_complete", out_valid, 0);
        drain("t5");

        // Reset in the 2nd SHIFT cycle: word discarded, pointer back to R-1
        req_data[2*N +: N] = 4'b0101;
        req_data[3*N +: N] = 4'b0111;
        req_valid = 4'b1000;
        wait_grant("t6_pre", g);
        check("t6_pre_gid", g, 3);
        step();
        req_valid[2] = 1'b1;
        step();
        rst_n = 1'b0;
        #2;
        check("t6_rst_valid", out_valid, 0);
        step();
        rst_n = 1'b1;
        push(4'b0101, 1'b1, 2'd2);
        push(4'b0111, 1'b0, 2'd3);
        for (int k = 0; k < 2; k++) begin
            wait_grant("t6", g);
            check("t6_order", g, k + 2);
            step();
            if (g >= 0) req_valid[g] = 1'b0;
        end
        drain("t6");

        // N=8 instance: 8'hFF has an even count of ones, so parity is 1
        req_data8[7:0] = 8'hFF;
        req_valid8     = 4'b0001;
        #1;
        check("n8_ready", req_ready8, 4'b0001);
        step();
        req_valid8 = '0;
        repeat (7) step();
        check("n8_latency_early", out_valid8, 0);
        step();
        check("n8_valid", out_valid8, 1);
        check("n8_data", out_data8, 8'hFF);
        check("n8_parity", out_parity8, 1);
        check("n8_id", out_id8, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
